// File: rtl/cpu_pkg.sv
// Shared memory-stage widths and the responder FSM encoding.
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/ram_array.sv
// Synchronous 1R1W storage, no reset; a same-address read returns the old word.
module ram_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/data_ram_responder.sv
// Load/store responder: one outstanding request, fixed LATENCY, held response.
module data_ram_responder
  import cpu_pkg::*;
#(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rsp_write;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_commit;
  logic [ADDR_W-1:0] w_raddr;
  logic [DATA_W-1:0] w_rdata;

  assign w_commit = (r_state == ST_WAIT) && (r_cnt == '0);
  // The array read is issued one edge ahead of commit: from the live request
  // on the accept edge (covers LATENCY==1), else from the latched address.
  assign w_raddr  = (r_state == ST_IDLE) ? req_addr : r_addr;

  ram_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .i_we    (w_commit && r_write),
    .i_waddr (r_addr),
    .i_wdata (r_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_write <= req_write;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_cnt   <= CNT_W'(LATENCY - 1);
          r_state <= ST_WAIT;
        end
        ST_WAIT: if (r_cnt == '0) begin
          r_rsp_write <= r_write;
          r_rsp_rdata <= r_write ? '0 : w_rdata;
          r_state     <= ST_RESP;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        ST_RESP: if (rsp_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_data_ram_responder.sv
// Randomized load/store bench for LATENCY=2 (d=0) and LATENCY=1 (d=1) responders.
module tb_data_ram_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_write [2];
  logic        rsp_ready [2];
  logic [3:0]  req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_write [2];
  logic        busy      [2];
  logic [15:0] rsp_rdata [2];

  logic [15:0] mdl [2][16];
  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_ram_responder #(.DATA_W(16), .ADDR_W(4), .LATENCY(2)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_write(rsp_write[0]),
    .rsp_rdata(rsp_rdata[0]), .busy(busy[0]));

  data_ram_responder #(.DATA_W(16), .ADDR_W(4), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_write(rsp_write[1]),
    .rsp_rdata(rsp_rdata[1]), .busy(busy[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_rst_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
      chk({tag, "_rsp_rdata"}, 32'(rsp_rdata[d]), 32'd0);
      chk({tag, "_busy"},      32'(busy[d]),      32'd0);
    end
  endtask

  // One full transaction; the model decides response contents and timing.
  task automatic txn(input int d, input bit wr, input logic [3:0] a,
                     input logic [15:0] wd, input int bp, input bit early);
    int lat;
    int k;
    logic [15:0] exp;
    lat = (d == 0) ? 2 : 1;
    exp = wr ? 16'h0 : mdl[d][a];
    @(negedge clk);
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = a; req_wdata[d] = wd;
    rsp_ready[d] = early;
    chk("idle_ready", 32'(req_ready[d]), 32'd1);
    @(posedge clk); #1;
    // Scramble the request lines: nothing after the accept edge may matter.
    req_valid[d] = 1'b0; req_write[d] = ~wr; req_addr[d] = 4'h7; req_wdata[d] = 16'h1234;
    chk("wait_busy", 32'(busy[d]), 32'd1);
    chk("wait_ready", 32'(req_ready[d]), 32'd0);
    k = 0;
    while (!rsp_valid[d] && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", 32'(k), 32'(lat));
    chk("rsp_write", 32'(rsp_write[d]), 32'(wr));
    chk("rsp_rdata", 32'(rsp_rdata[d]), 32'(exp));
    if (!early) begin
      for (int i = 0; i < bp; i++) begin
        @(posedge clk); #1;
        chk("bp_valid", 32'(rsp_valid[d]), 32'd1);
        chk("bp_rdata", 32'(rsp_rdata[d]), 32'(exp));
        chk("bp_ready", 32'(req_ready[d]), 32'd0);
      end
      rsp_ready[d] = 1'b1;
    end
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    chk("hs_valid", 32'(rsp_valid[d]), 32'd0);
    chk("hs_idle", 32'(req_ready[d]), 32'd1);
    chk("hs_rdata_kept", 32'(rsp_rdata[d]), 32'(exp));
    if (wr) mdl[d][a] = wd;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; rsp_ready[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_rst_outputs("por");
    @(negedge clk) rst_n = 1'b1;

    // Known contents everywhere; dut0 addr 0xF pre-written with 0.
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 16; a++)
        txn(d, 1'b1, 4'(a), (d == 0 && a == 15) ? 16'h0 : 16'($urandom), 0, 1'b1);

    // Store/load, ready already high; backpressure; latched-request check.
    txn(0, 1'b1, 4'h3, 16'hBEEF, 0, 1'b1);
    txn(0, 1'b0, 4'h3, 16'h0, 0, 1'b1);
    txn(0, 1'b0, 4'h3, 16'h0, 5, 1'b0);
    txn(0, 1'b1, 4'h2, 16'hA5A5, 0, 1'b0);
    txn(0, 1'b0, 4'h7, 16'h0, 0, 1'b0);
    txn(0, 1'b0, 4'h2, 16'h0, 0, 1'b0);

    // Reset one cycle after accepting a store, before its commit edge.
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 4'hF; req_wdata[0] = 16'h5555;
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk_rst_outputs("midop");
    @(negedge clk) rst_n = 1'b1;
    txn(0, 1'b0, 4'hF, 16'h0, 0, 1'b0);

    // LATENCY=1: array ends and same-address store-then-load.
    txn(1, 1'b1, 4'h0, 16'hC0DE, 0, 1'b0);
    txn(1, 1'b1, 4'hF, 16'hF00D, 2, 1'b0);
    txn(1, 1'b0, 4'h0, 16'h0, 0, 1'b0);
    txn(1, 1'b0, 4'hF, 16'h0, 1, 1'b1);

    for (int i = 0; i < 80; i++)
      txn(i % 2, 1'($urandom), 4'($urandom), 16'($urandom),
          int'($urandom_range(0, 3)), 1'($urandom));

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
